// File: rtl/score_seg_driver.sv
// score_seg_driver: latches BCD score digits and drives two active-low 7-seg displays, flashing on change.
// Optional leading-zero blanking of the tens digit when SEG_LZB_EN is defined.
module score_seg_driver #(
  parameter int BLINK_DIV   = 12_500_000,
  parameter int BLINK_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       load,
  output logic       busy,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);
  localparam int HW = $clog2(BLINK_DIV + 1);
  localparam int PW = $clog2(2 * BLINK_COUNT + 1);
  localparam logic [HW-1:0] HMAX = HW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] PMAX = PW'(2 * BLINK_COUNT - 1);
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef SEG_LZB_EN
  localparam logic [6:0] RST_H1 = BLANK;
`else
  localparam logic [6:0] RST_H1 = 7'b1000000;
`endif

  typedef enum logic {IDLE, FLASH} state_t;

  state_t        state, n_state;
  logic [HW-1:0] half_cnt, n_half;
  logic [PW-1:0] phase_cnt, n_phase;
  logic          blank, n_blank, lzb;
  logic [3:0]    dig_t, dig_o, n_t, n_o;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
  endfunction

  // Any load while flashing restarts, even for an unchanged score
  always_comb begin
    n_state = state;
    n_half  = half_cnt;
    n_phase = phase_cnt;
    n_blank = blank;
    n_t     = load ? tens : dig_t;
    n_o     = load ? ones : dig_o;
    if (load && (state == FLASH || {tens, ones} != {dig_t, dig_o})) begin
      n_state = FLASH;
      n_half  = '0;
      n_phase = '0;
      n_blank = 1'b1;
    end else if (state == FLASH) begin
      if (half_cnt == HMAX) begin
        n_half  = '0;
        n_blank = ~blank;
        n_phase = phase_cnt + 1'b1;
        if (phase_cnt == PMAX) begin
          n_state = IDLE;
          n_blank = 1'b0;
          n_phase = '0;
        end
      end else begin
        n_half = half_cnt + 1'b1;
      end
    end
  end

`ifdef SEG_LZB_EN
  assign lzb = (n_t == 4'd0);
`else
  assign lzb = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      half_cnt  <= '0;
      phase_cnt <= '0;
      blank     <= 1'b0;
      dig_t     <= '0;
      dig_o     <= '0;
      busy      <= 1'b0;
      hex1      <= RST_H1;
      hex0      <= 7'b1000000;
    end else begin
      state     <= n_state;
      half_cnt  <= n_half;
      phase_cnt <= n_phase;
      blank     <= n_blank;
      dig_t     <= n_t;
      dig_o     <= n_o;
      busy      <= (n_state == FLASH);
      hex1      <= (n_blank || lzb) ? BLANK : seg(n_t);
      hex0      <= n_blank ? BLANK : seg(n_o);
    end
  end
endmodule

// File: tb/tb_score_seg_driver.sv
// tb_score_seg_driver: table vectors, corner sequences and random loads against an elapsed-time display model.
module tb_score_seg_driver;
  localparam int D = 4, C = 2, TOT = 2 * C * D;
`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    logic [3:0] t, o;
    logic [6:0] h1, h0;
  } vec_t;

  logic       clk = 1'b0, rst_n = 1'b1, load = 1'b0;
  logic [3:0] tens = '0, ones = '0;
  logic       busy;
  logic [6:0] hex1, hex0;

  int         checks = 0, failures = 0;
  int         m_el = 1000;
  logic [3:0] m_t = '0, m_o = '0;
  logic [6:0] seg_tab [16];
  vec_t       v [7];

  score_seg_driver #(.BLINK_DIV(D), .BLINK_COUNT(C)) dut (
    .clk(clk), .rst_n(rst_n), .tens(tens), .ones(ones), .load(load),
    .busy(busy), .hex1(hex1), .hex0(hex0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b t=%0t", name, got, exp, $time);
    end
  endtask

  // Display is a pure function of time since the last accepted load
  function automatic logic [14:0] model_out();
    logic b, blk;
    b   = m_el < TOT;
    blk = b && ((m_el / D) % 2 == 0);
    return {b, (blk || (LZB && m_t == 4'd0)) ? 7'h7f : seg_tab[m_t], blk ? 7'h7f : seg_tab[m_o]};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (load && (m_el < TOT || {tens, ones} != {m_t, m_o})) m_el = 0;
    else if (m_el < TOT) m_el++;
    if (load) begin
      m_t = tens;
      m_o = ones;
    end
    #1;
    chk("model", {busy, hex1, hex0}, model_out());
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    tens = t;
    ones = o;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic model_reset();
    m_el = 1000;
    m_t  = '0;
    m_o  = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) seg_tab[i] = 7'b0111111;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    v[0] = '{4'd4,  4'd2, 7'b0011001, 7'b0100100};
    v[1] = '{4'd12, 4'd5, 7'b0111111, 7'b0010010};
    v[2] = '{4'd0,  4'd7, LZB ? 7'b1111111 : 7'b1000000, 7'b1111000};
    v[3] = '{4'd1,  4'd0, 7'b1111001, 7'b1000000};
    v[4] = '{4'd9,  4'd6, 7'b0010000, 7'b0000010};
    v[5] = '{4'd15, 4'd3, 7'b0111111, 7'b0110000};
    v[6] = '{4'd7,  4'd8, 7'b1111000, 7'b0000000};

    #1 rst_n = 1'b0;
    #2 chk("reset", {busy, hex1, hex0}, {1'b0, LZB ? 7'b1111111 : 7'b1000000, 7'b1000000});
    #9 rst_n = 1'b1;
    tick();

    // Score change 00 -> 42: blank 4, show 4, blank 4, show 4, then idle
    do_load(4'd4, 4'd2);
    chk("chg_blank", {busy, hex1, hex0}, {1'b1, 7'h7f, 7'h7f});
    repeat (D) tick();
    chk("chg_show", {busy, hex1, hex0}, {1'b1, 7'b0011001, 7'b0100100});
    repeat (TOT - D - 1) tick();
    chk("chg_last", busy, 1'b1);
    tick();
    chk("chg_done", {busy, hex1, hex0}, {1'b0, 7'b0011001, 7'b0100100});

    // Same score while idle is invisible
    do_load(4'd4, 4'd2);
    repeat (20) tick();
    chk("same", {busy, hex1, hex0}, {1'b0, 7'b0011001, 7'b0100100});

    // Reload 43 at cycle 6 of a flash
    do_load(4'd1, 4'd1);
    repeat (5) tick();
    do_load(4'd4, 4'd3);
    chk("reload_blank", {busy, hex0}, {1'b1, 7'h7f});
    repeat (D) tick();
    chk("reload_show", hex0, 7'b0110000);
    repeat (TOT - D - 1) tick();
    chk("reload_busy", busy, 1'b1);
    tick();
    chk("reload_end", busy, 1'b0);

    // Held load restarts each cycle, even with identical digits
    do_load(4'd5, 4'd5);
    repeat (3) tick();
    tens = 4'd5; ones = 4'd5; load = 1'b1;
    repeat (3) tick();
    load = 1'b0;
    repeat (TOT - 1) tick();
    chk("held_busy", busy, 1'b1);
    tick();
    chk("held_end", busy, 1'b0);

    for (int i = 0; i < 7; i++) begin
      do_load(v[i].t, v[i].o);
      repeat (TOT + 2) tick();
      chk($sformatf("vec%0d", i), {busy, hex1, hex0}, {1'b0, v[i].h1, v[i].h0});
    end

    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 2) == 0) begin
        tens = m_t;
        ones = m_o;
      end else begin
        tens = 4'($urandom_range(0, 15));
        ones = 4'($urandom_range(0, 15));
      end
      tick();
    end
    load = 1'b0;

    // Asynchronous reset mid-flash
    do_load(4'd8, 4'd1);
    repeat (3) tick();
    #3 rst_n = 1'b0;
    #1 chk("reset_mid", {busy, hex1, hex0}, {1'b0, LZB ? 7'b1111111 : 7'b1000000, 7'b1000000});
    model_reset();
    #1 rst_n = 1'b1;
    repeat (3) tick();
    do_load(4'd0, 4'd0);
    chk("post_reset_same", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/score_seg_driver.md
# score_seg_driver

Downstream stage of the binary-to-BCD score converter: it latches the BCD tens/ones digits on a load strobe and drives two active-low seven-segment displays (HEX1 = tens, HEX0 = ones). When the score changes, the new score flashes a programmable number of times before it holds steady. It sits between the score/BCD path and the board HEX pins. All outputs are registered.

## Interface
- BLINK_DIV, 12_500_000: clk cycles per blink half-period (0.25 s at 50 MHz); legal range ≥ 1.
- BLINK_COUNT, 3: number of blank/show flash pairs per score change; legal range ≥ 1.
- clk  in  1  system clock; the block uses one clock.
- rst_n  in  1  asynchronous reset, active-low.
- tens  in  4  BCD tens digit from the converter.
- ones  in  4  BCD ones digit from the converter.
- load  in  1  single-cycle strobe, sampled on the rising edge of clk; latches tens/ones.
- busy  out  1  high while a flash sequence is in progress.
- hex1  out  7  tens segments, active-low, bit order {g,f,e,d,c,b,a}.
- hex0  out  7  ones segments, active-low, same order.

## Operation
- **State machine:** IDLE, FLASH.
- **Registers:**
  - dig_t and dig_o: latched digits, reset to 0.
  - half_cnt: counts 0..BLINK_DIV-1; width is $clog2(BLINK_DIV+1).
  - phase_cnt: counts 0..2*BLINK_COUNT-1.
  - blank flag.
- **IDLE:**
  - Displays dig_t and dig_o steadily.
  - On load, latch tens/ones.
  - If the new value is not equal to {dig_t, dig_o}: go to FLASH, clear half_cnt and phase_cnt, set blank=1.
  - If the new value is equal: remain in IDLE with no visible change.
- **FLASH:**
  - half_cnt increments every cycle.
  - When half_cnt reaches BLINK_DIV-1: half_cnt←0, blank toggles, phase_cnt increments.
  - When phase_cnt reaches 2*BLINK_COUNT-1 and half_cnt reaches BLINK_DIV-1: go to IDLE with blank=0.
- **load during FLASH:**
  - Latch the new digits and restart the sequence: half_cnt←0, phase_cnt←0, blank←1.
  - The restart happens even if the new digits equal the current ones.
- **Digit decode (active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10–15 shows "-" (0111111). This covers a tens value above 9 from a score over 99.
- **Blank:** both digits show 1111111 while blank=1.
- **Digit range:** inputs are not range-checked beyond the "-" decode.
- **busy:** 1 exactly when state is FLASH.

## Timing
- **Reset (rst_n low, asynchronous):**
  - state=IDLE, busy=0, dig_t=dig_o=0.
  - hex0=1000000.
  - hex1=1000000, or 1111111 when SEG_LZB_EN is defined.
- **Output latency:**
  - The hex and busy registers are loaded from next-state values.
  - A load sampled at edge k is visible on hex1/hex0 and busy immediately after edge k.
- **Flash sequence, starting from a load at edge k:**
  - Blank for BLINK_DIV cycles, then shown for BLINK_DIV cycles; the pair repeats BLINK_COUNT times.
  - busy falls after edge k+2·BLINK_COUNT·BLINK_DIV.
  - The last shown half-period is still counted as FLASH.
- **Reset mid-flash:** returns to the reset values immediately and the sequence is lost.
- **load held high for multiple cycles:** each sampled cycle is treated as a load. In FLASH this restarts the sequence every cycle.

## Configuration
- **SEG_LZB_EN** (leading-zero blanking).
  - Defined: hex1 shows 1111111 whenever dig_t==0, outside of blank phases too. Scores 0–9 therefore show a single digit.
  - Undefined: tens digit 0 shows "0".
  - The ones digit is never blanked by this option.

## Test plan
Use BLINK_DIV=4 and BLINK_COUNT=2 unless stated.
- **Reset:** rst_n low mid-cycle → hex0=1000000, busy=0 immediately, without waiting for a clock edge. hex1=1000000 (LZB off) or 1111111 (LZB on).
- **Score change:** load with tens=4, ones=2 from 00 → after edge k, busy=1 and both hex=1111111 for 4 cycles. Then hex1=0011001, hex0=0100100 for 4 cycles, then blank 4, then show. busy=0 after edge k+16.
- **Same score:** load 42 while 42 is displayed in IDLE → busy stays 0 and hex stays steady for 20 cycles.
- **Reload mid-flash:** load 43 at cycle 6 of a flash → blank restarts from the next edge with hex0=0110000. busy=1 for 16 cycles from the reload.
- **Out-of-range tens:** load with tens=12, ones=5 (score 125) → hex1=0111111, hex0=0010010 after the flash completes.
- **LZB on:** load with tens=0, ones=7 → hex1=1111111 and hex0=1111000 in steady state. Then load with tens=1, ones=0 → hex1=1111001.
